// File: rtl/nano_mem_responder.sv
// NanoCPU memory-side responder: 256x16 word store, host program loader and an output register
// mapped at IO_ADDR. The CPU is held while the store is idle or being loaded.
module nano_mem_responder #(
   parameter logic [7:0]  IO_ADDR = 8'hFF,
   parameter int unsigned DEPTH   = 256
) (
   input  logic        ck,
   input  logic        rst,
   input  logic [7:0]  address,
   output logic [15:0] dataR,
   input  logic [15:0] dataW,
   input  logic        ce,
   input  logic        we,
   input  logic        ld_start,
   input  logic [8:0]  ld_len,
   input  logic        ld_valid,
   input  logic [15:0] ld_data,
   output logic        ld_ready,
   output logic        cpu_hold,
   output logic [15:0] io_out,
   output logic        io_strobe,
   output logic [15:0] wr_count
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   state_e      state_q;
   logic [7:0]  ptr_q;
   logic [8:0]  len_q;
   logic        ld_ready_q;
   logic        cpu_hold_q;
   logic [15:0] io_out_q;
   logic        io_strobe_q;
   logic [15:0] wr_count_q;

   logic [15:0] mem [DEPTH];

   logic cpu_wr;
   logic io_wr;
   logic ld_acc;
   logic ld_last;

   always_comb begin
      cpu_wr  = (state_q == StRun) && ce && we;
      io_wr   = cpu_wr && (address == IO_ADDR);
      ld_acc  = (state_q == StLoad) && ld_valid;
      // len_q is at least 1 in LOAD, so len_q-1 never underflows; ptr wraps only after word 255.
      ld_last = ld_acc && ({1'b0, ptr_q} == (len_q - 9'd1));
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= 8'd0;
         len_q       <= 9'd0;
         ld_ready_q  <= 1'b0;
         cpu_hold_q  <= 1'b1;
         io_out_q    <= 16'h0000;
         io_strobe_q <= 1'b0;
         wr_count_q  <= 16'h0000;
      end else begin
         io_strobe_q <= io_wr;
         if (io_wr) begin
            io_out_q <= dataW;
         end
         if (cpu_wr && (wr_count_q != 16'hFFFF)) begin
            wr_count_q <= wr_count_q + 16'd1;
         end

         unique case (state_q)
            StIdle: begin
               if (ld_start) begin
                  if (ld_len == 9'd0) begin
                     state_q    <= StRun;
                     ld_ready_q <= 1'b0;
                     cpu_hold_q <= 1'b0;
                  end else begin
                     state_q    <= StLoad;
                     ptr_q      <= 8'd0;
                     len_q      <= ld_len;
                     ld_ready_q <= 1'b1;
                     cpu_hold_q <= 1'b1;
                  end
               end
            end
            StLoad: begin
               if (ld_acc) begin
                  ptr_q <= ptr_q + 8'd1;
                  if (ld_last) begin
                     state_q    <= StRun;
                     ld_ready_q <= 1'b0;
                     cpu_hold_q <= 1'b0;
                  end
               end
            end
            StRun: begin
               if (ld_start && (ld_len != 9'd0)) begin
                  state_q    <= StLoad;
                  ptr_q      <= 8'd0;
                  len_q      <= ld_len;
                  ld_ready_q <= 1'b1;
                  cpu_hold_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= StIdle;
               ld_ready_q <= 1'b0;
               cpu_hold_q <= 1'b1;
            end
         endcase
      end
   end

   // The array has no reset; writes are gated off on a reset edge so an abandoned load stops cleanly.
   always_ff @(posedge ck) begin
      if (!rst) begin
         if (ld_acc) begin
            mem[ptr_q] <= ld_data;
         end else if (cpu_wr && !io_wr) begin
            mem[address] <= dataW;
         end
      end
   end

   always_comb begin
      dataR = 16'h0000;
      if ((state_q == StRun) && ce) begin
         dataR = (address == IO_ADDR) ? io_out_q : mem[address];
      end
   end

   assign ld_ready  = ld_ready_q;
   assign cpu_hold  = cpu_hold_q;
   assign io_out    = io_out_q;
   assign io_strobe = io_strobe_q;
   assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_nano_mem_responder.sv
// Directed plus randomized bench for nano_mem_responder against a word-level behavioural model.
module tb_nano_mem_responder;

   logic        ck = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  address = 8'h00;
   logic [15:0] dataR;
   logic [15:0] dataW = 16'h0000;
   logic        ce = 1'b0;
   logic        we = 1'b0;
   logic        ld_start = 1'b0;
   logic [8:0]  ld_len = 9'd0;
   logic        ld_valid = 1'b0;
   logic [15:0] ld_data = 16'h0000;
   logic        ld_ready;
   logic        cpu_hold;
   logic [15:0] io_out;
   logic        io_strobe;
   logic [15:0] wr_count;

   always #5 ck = ~ck;

   nano_mem_responder dut (
      .ck        (ck),
      .rst       (rst),
      .address   (address),
      .dataR     (dataR),
      .dataW     (dataW),
      .ce        (ce),
      .we        (we),
      .ld_start  (ld_start),
      .ld_len    (ld_len),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .cpu_hold  (cpu_hold),
      .io_out    (io_out),
      .io_strobe (io_strobe),
      .wr_count  (wr_count)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: word store plus a few behavioural flags.
   logic [15:0] mem_m [256];
   bit          known   = 1'b0;
   bit          running = 1'b0;
   bit          loading = 1'b0;
   int          left_m  = 0;
   logic [7:0]  ptr_m   = 8'd0;
   logic [15:0] io_m    = 16'h0000;
   logic [15:0] cnt_m   = 16'h0000;
   bit          strobe_m = 1'b0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         known    = 1'b1;
         running  = 1'b0;
         loading  = 1'b0;
         left_m   = 0;
         ptr_m    = 8'd0;
         io_m     = 16'h0000;
         strobe_m = 1'b0;
         cnt_m    = 16'h0000;
      end else if (known) begin
         strobe_m = 1'b0;
         if (loading) begin
            if (ld_valid) begin
               mem_m[ptr_m] = ld_data;
               ptr_m = ptr_m + 8'd1;
               left_m--;
               if (left_m == 0) begin
                  loading = 1'b0;
                  running = 1'b1;
               end
            end
         end else begin
            if (running && ce && we) begin
               if (address == 8'hFF) begin
                  io_m = dataW;
                  strobe_m = 1'b1;
               end else begin
                  mem_m[address] = dataW;
               end
               if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            end
            if (ld_start && (ld_len != 9'd0)) begin
               running = 1'b0;
               loading = 1'b1;
               left_m  = int'(ld_len);
               ptr_m   = 8'd0;
            end else if (ld_start && !running) begin
               running = 1'b1;
            end
         end
      end
   endtask

   // Check combinational read before the edge, advance the model, check registered state after it.
   task automatic cycle(input string tag);
      logic [15:0] exp_r;
      #1;
      if (known) begin
         exp_r = (running && ce) ? ((address == 8'hFF) ? io_m : mem_m[address]) : 16'h0000;
         chk({tag, ".dataR"}, dataR, exp_r);
      end
      model_edge();
      @(posedge ck);
      #1;
      if (known) begin
         chk({tag, ".cpu_hold"}, {15'd0, cpu_hold}, {15'd0, !running});
         chk({tag, ".ld_ready"}, {15'd0, ld_ready}, {15'd0, loading});
         chk({tag, ".io_out"}, io_out, io_m);
         chk({tag, ".io_strobe"}, {15'd0, io_strobe}, {15'd0, strobe_m});
         chk({tag, ".wr_count"}, wr_count, cnt_m);
      end
   endtask

   initial begin
      // Reset and idle outputs
      rst = 1'b1;
      cycle("reset0");
      cycle("reset1");
      rst = 1'b0;
      ce = 1'b1;
      address = 8'h05;
      cycle("idle");
      chk("idle_hold", {15'd0, cpu_hold}, 16'd1);
      chk("idle_dataR", dataR, 16'h0000);

      // Three-word load and read back
      ce = 1'b0;
      ld_start = 1'b1;
      ld_len = 9'd3;
      cycle("ld3_start");
      ld_start = 1'b0;
      ld_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("ld3_ready", {15'd0, ld_ready}, 16'd1);
         ld_data = 16'h4000 + 16'(i) * 16'h0111;
         cycle("ld3_word");
      end
      ld_valid = 1'b0;
      chk("ld3_run", {15'd0, cpu_hold}, 16'd0);
      ce = 1'b1;
      for (int a = 0; a < 3; a++) begin
         address = 8'(a);
         cycle("ld3_read");
         chk("ld3_lit", dataR, 16'h4000 + 16'(a) * 16'h0111);
      end

      // Full-depth load with stalls and an ignored ld_start
      ce = 1'b0;
      ld_start = 1'b1;
      ld_len = 9'd256;
      cycle("ld256_start");
      ld_len = 9'd4;
      for (int i = 0; i < 512; i++) begin
         ld_start = (i == 100);
         ld_valid = (i % 2 == 0);
         ld_data  = 16'(i / 2);
         cycle("ld256");
      end
      ld_start = 1'b0;
      ld_valid = 1'b0;
      chk("ld256_run", {15'd0, cpu_hold}, 16'd0);
      ce = 1'b1;
      for (int a = 0; a < 255; a++) begin
         address = 8'(a);
         cycle("ld256_read");
         chk("ld256_lit", dataR, 16'(a));
      end

      // CPU write with read-during-write, then a write with ce low
      address = 8'd16;
      dataW = 16'h000A;
      we = 1'b1;
      #1;
      chk("rdw_old", dataR, 16'h0010);
      cycle("wr16");
      we = 1'b0;
      cycle("wr16_read");
      chk("wr16_new", dataR, 16'h000A);
      chk("wr16_cnt", wr_count, 16'd1);
      ce = 1'b0;
      we = 1'b1;
      dataW = 16'h1234;
      cycle("wr16_ce0");
      ce = 1'b1;
      we = 1'b0;
      cycle("wr16_ce0_read");
      chk("wr16_ce0_lit", dataR, 16'h000A);
      chk("wr16_ce0_cnt", wr_count, 16'd1);

      // IO register, shadowing of word 255, back-to-back strobes
      address = 8'hFF;
      dataW = 16'hBEEF;
      we = 1'b1;
      cycle("io_wr");
      chk("io_strobe1", {15'd0, io_strobe}, 16'd1);
      chk("io_val", io_out, 16'hBEEF);
      we = 1'b0;
      cycle("io_read");
      chk("io_strobe0", {15'd0, io_strobe}, 16'd0);
      chk("io_rd", dataR, 16'hBEEF);
      chk("mem255", dut.mem[255], 16'h00FF);
      we = 1'b1;
      dataW = 16'h1111;
      cycle("io_b2b0");
      dataW = 16'h2222;
      cycle("io_b2b1");
      chk("io_b2b_strobe", {15'd0, io_strobe}, 16'd1);
      we = 1'b0;
      cycle("io_b2b_end");

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         ce       = 1'($urandom);
         we       = 1'($urandom);
         address  = 8'($urandom);
         dataW    = 16'($urandom);
         ld_start = ($urandom_range(0, 19) == 0);
         ld_len   = 9'($urandom_range(0, 8));
         ld_valid = 1'($urandom);
         ld_data  = 16'($urandom);
         cycle("rand");
      end

      // Reload from RUN, writes ignored while held, reset mid-load
      rst = 1'b1;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ce = 1'b0;
      we = 1'b0;
      cycle("rl_rst");
      rst = 1'b0;
      ld_start = 1'b1;
      ld_len = 9'd0;
      cycle("rl_run");
      ld_len = 9'd5;
      ce = 1'b1;
      we = 1'b1;
      address = 8'd3;
      dataW = 16'h7777;
      cycle("rl_start");
      chk("rl_hold", {15'd0, cpu_hold}, 16'd1);
      ld_start = 1'b0;
      address = 8'd4;
      dataW = 16'h5555;
      ld_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ld_data = 16'hAA00 + 16'(i);
         cycle("rl_word");
      end
      rst = 1'b1;
      ld_data = 16'hFFFF;
      cycle("rl_mid_rst");
      rst = 1'b0;
      ld_valid = 1'b0;
      we = 1'b0;
      chk("rl_idle_hold", {15'd0, cpu_hold}, 16'd1);
      chk("rl_idle_ready", {15'd0, ld_ready}, 16'd0);
      ld_start = 1'b1;
      ld_len = 9'd0;
      cycle("rl_go");
      ld_start = 1'b0;
      for (int a = 0; a < 5; a++) begin
         address = 8'(a);
         cycle("rl_read");
         if (a < 2) chk("rl_kept", dataR, 16'hAA00 + 16'(a));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/nano_mem_responder.md
Name: nano_mem_responder

Overview:
- Memory-side responder for the NanoCPU bus: 256 x 16-bit word store serving the CPU's `address`/`dataR`/`dataW`/`ce`/`we` accesses.
- Adds a program-loader FSM. A host streams words into the store through a valid/ready handshake while the CPU is held.
- Adds a memory-mapped output register at address 0xFF.
- Sits between the CPU and the top level, replacing the bench-side behavioural memory.

Parameters:
- IO_ADDR, 8'hFF, CPU address decoded as the output register instead of the store.
- DEPTH, 256, number of 16-bit words (fixed to 2^8).

Ports:
- ck  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- address  input  8  CPU word address.
- dataR  output  16  read data to CPU (combinational).
- dataW  input  16  write data from CPU.
- ce  input  1  CPU access enable.
- we  input  1  CPU write enable (qualified by ce).
- ld_start  input  1  one-cycle request to begin a load.
- ld_len  input  9  number of words to load, 0..256; sampled with ld_start.
- ld_valid  input  1  loader word valid.
- ld_data  input  16  loader word.
- ld_ready  output  1  loader may accept a word this cycle.
- cpu_hold  output  1  CPU must be held in reset/stall while high.
- io_out  output  16  output register contents.
- io_strobe  output  1  one-cycle pulse after each CPU write to IO_ADDR.
- wr_count  output  16  count of accepted CPU writes, saturating.

Behaviour:
- Reset and states:
  - Reset (rst=1 at edge): state=IDLE, load pointer=0, io_out=0, io_strobe=0, wr_count=0.
  - Reset does not clear the word array.
  - Reset mid-LOAD abandons the load; words already written remain.
- FSM states: IDLE, LOAD, RUN.
- Outputs by state:
  - ld_ready = (state==LOAD).
  - cpu_hold = (state!=RUN).
  - All outputs are registered or decoded from registered state, except dataR.
- IDLE:
  - ld_start with ld_len=0 -> RUN.
  - ld_start with ld_len>0 -> LOAD; ptr=0; len latched.
- LOAD:
  - Each cycle with ld_valid=1 (ld_ready is 1): mem[ptr] <= ld_data, then ptr++.
  - On the accepted word where ptr==len-1 -> RUN the next cycle. ptr is 8 bits and wraps from 255 to 0 only after the final word of a 256-word load.
  - ld_start is ignored in LOAD.
  - CPU bus writes are ignored in LOAD.
- RUN:
  - ld_start with ld_len>0 -> LOAD (cpu_hold rises the next cycle).
  - ld_start with ld_len=0 is ignored.
  - ld_valid is ignored outside LOAD.
- CPU read (combinational, zero latency):
  - state==RUN and ce=1 and address==IO_ADDR: dataR = io_out.
  - state==RUN and ce=1, any other address: dataR = mem[address].
  - Otherwise dataR = 16'h0000.
- CPU write (state==RUN, ce=1, we=1, at rising edge):
  - address==IO_ADDR: io_out <= dataW; io_strobe=1 for exactly the next cycle.
  - Otherwise: mem[address] <= dataW.
  - wr_count increments by 1 for every accepted write, saturating at 16'hFFFF.
- Read-during-write, same address, same cycle: dataR returns the old value; the new value is visible from the next cycle.
- Word 255 of the array is writable by the loader only; it is shadowed by IO_ADDR on the CPU side.
- Back-to-back IO writes keep io_strobe high on consecutive cycles, one pulse per write.

Test Plan:
- Reset then check outputs: rst=1 for 2 cycles, then idle -> cpu_hold=1, ld_ready=0, io_out=0, io_strobe=0, wr_count=0, dataR=0 with ce=1.
- Load and read back: ld_start, ld_len=3; stream 16'h4000, 16'h4111, 16'h4222 with ld_valid held high -> ld_ready high for 3 cycles, then state RUN and cpu_hold=0. Reading address 0,1,2 with ce=1 -> 16'h4000, 16'h4111, 16'h4222.
- Loader stall and full-depth load: ld_len=256 with ld_valid toggled every other cycle -> exactly 256 words written, mem[i]=i, RUN entered after the 256th accepted word. A ld_start issued during the load is ignored.
- CPU write and read-during-write: in RUN, write 16'h000A to address 16 -> same-cycle dataR=old value, next cycle dataR=16'h000A, wr_count=1. The same write with ce=0 -> no change.
- IO register: write 16'hBEEF to 8'hFF -> io_out=16'hBEEF and io_strobe=1 for one cycle. A read of 8'hFF returns 16'hBEEF, and the array word 255 is unchanged.
- Reload and reset mid-operation: ld_start in RUN -> cpu_hold=1 the next cycle, and CPU writes are ignored while held. Assert rst after 2 loaded words of a 5-word load -> IDLE, ptr=0, and words 0..1 hold their loaded values.
